// File: rtl/dlfloat_div_seq_pkg.sv
// Shared DLFloat16 definitions: field widths, special encodings, operand
// classification and the divider state encoding.
package dlfloat_pkg;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;
  localparam int QBITS = MAN_W + 3;

  localparam logic [15:0] DLF_NAN_INF = 16'hFFFF;
  localparam logic [15:0] DLF_ZERO    = 16'h0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } dlfloat_t;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_t;

  // Subnormals are flushed, so a zero exponent alone marks zero.
  function automatic logic is_zero(dlfloat_t x);
    return x.exp == '0;
  endfunction

  function automatic logic is_nan_inf(dlfloat_t x);
    return x.exp == '1;
  endfunction
endpackage

// File: rtl/dlfloat_div_seq_if.sv
// Operand/result handshake bundle for the DLFloat16 divider.
interface dlfloat_div_seq_if;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        out_valid, out_ready;
  logic [15:0] c;
  logic        dz, ovf, unf;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, c, dz, ovf, unf);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, c, dz, ovf, unf);
endinterface

// File: rtl/dlfloat_div_seq_round_pack.sv
// Normalize a 2^0..2^-11 weighted quotient, round to nearest even and pack
// into DLFloat16 with overflow/underflow saturation.
module dlfloat_round_pack
  import dlfloat_pkg::*;
(
  input  logic [QBITS-1:0]  q,
  input  logic              rem_nz,
  input  logic              sign,
  input  logic signed [7:0] exp_tmp,
  output logic [15:0]       c,
  output logic              ovf,
  output logic              unf
);
  localparam logic signed [7:0] EXP_MAX = 8'sd63;

  logic [MAN_W-1:0]  man_pre;
  logic [MAN_W:0]    man_rnd;
  logic              guard, sticky, inc;
  logic signed [7:0] exp_n;
  dlfloat_t          res;

  always_comb begin
    if (q[QBITS-1]) begin
      man_pre = q[QBITS-2:2];
      guard   = q[1];
      sticky  = q[0] | rem_nz;
      exp_n   = exp_tmp;
    end else begin
      man_pre = q[QBITS-3:1];
      guard   = q[0];
      sticky  = rem_nz;
      exp_n   = exp_tmp - 8'sd1;
    end
    inc     = guard & (sticky | man_pre[0]);
    // Carry out of the mantissa leaves man_rnd[MAN_W-1:0] at zero already.
    man_rnd = {1'b0, man_pre} + {{MAN_W{1'b0}}, inc};
    if (man_rnd[MAN_W]) exp_n = exp_n + 8'sd1;

    res = '0;
    ovf = 1'b0;
    unf = 1'b0;
    if (exp_n >= EXP_MAX) begin
      c   = DLF_NAN_INF;
      ovf = 1'b1;
    end else if (exp_n <= 8'sd0) begin
      c   = DLF_ZERO;
      unf = 1'b1;
    end else begin
      res.sign = sign;
      res.exp  = exp_n[EXP_W-1:0];
      res.man  = man_rnd[MAN_W-1:0];
      c        = res;
    end
  end
endmodule

// File: rtl/dlfloat_div_seq.sv
// Iterative DLFloat16 divider c = a / b: one restoring quotient bit per
// cycle, then a single normalize/round/pack cycle.
module dlfloat_div_seq
  import dlfloat_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  dlfloat_div_seq_if.slave bus
);
  div_state_t        state, state_nx;
  dlfloat_t          a_in, b_in;
  logic              sign_r;
  logic signed [7:0] exp_r;
  logic [MAN_W+1:0]  rem_r, rem_nx;
  logic [MAN_W:0]    div_r;
  logic [QBITS-1:0]  q_r;
  logic [3:0]        cnt_r;
  logic [15:0]       c_r, spec_c, rp_c;
  logic              dz_r, ovf_r, unf_r;
  logic              spec_case, spec_dz, q_bit, rp_ovf, rp_unf;

  assign a_in = bus.a;
  assign b_in = bus.b;

  always_comb begin
    spec_case = 1'b1;
    spec_c    = DLF_NAN_INF;
    spec_dz   = 1'b0;
    if (is_nan_inf(a_in) || is_nan_inf(b_in)) begin
      spec_c = DLF_NAN_INF;
    end else if (is_zero(b_in)) begin
      spec_dz = !is_zero(a_in);
    end else if (is_zero(a_in)) begin
      spec_c = DLF_ZERO;
    end else begin
      spec_case = 1'b0;
    end
  end

  // Remainder stays below 2*div, so the shifted-out top bit is always zero.
  assign q_bit  = rem_r >= {1'b0, div_r};
  assign rem_nx = q_bit ? rem_r - {1'b0, div_r} : rem_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = spec_case ? DONE : DIV;
      end
      DIV:  if (cnt_r == 4'(QBITS-1)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
      exp_r  <= '0;
      rem_r  <= '0;
      div_r  <= '0;
      q_r    <= '0;
      cnt_r  <= '0;
      c_r    <= DLF_ZERO;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dz_r  <= 1'b0;
          ovf_r <= 1'b0;
          unf_r <= 1'b0;
          if (spec_case) begin
            c_r  <= spec_c;
            dz_r <= spec_dz;
          end else begin
            sign_r <= a_in.sign ^ b_in.sign;
            exp_r  <= {2'b00, a_in.exp} - {2'b00, b_in.exp} + 8'(BIAS);
            rem_r  <= {2'b01, a_in.man};
            div_r  <= {1'b1, b_in.man};
            q_r    <= '0;
            cnt_r  <= '0;
          end
        end
        DIV: begin
          rem_r <= rem_nx << 1;
          q_r   <= {q_r[QBITS-2:0], q_bit};
          cnt_r <= cnt_r + 4'd1;
        end
        NORM: begin
          c_r   <= rp_c;
          ovf_r <= rp_ovf;
          unf_r <= rp_unf;
        end
        default: ;
      endcase
    end
  end

  dlfloat_round_pack u_round_pack (
    .q       (q_r),
    .rem_nz  (|rem_r),
    .sign    (sign_r),
    .exp_tmp (exp_r),
    .c       (rp_c),
    .ovf     (rp_ovf),
    .unf     (rp_unf)
  );

  assign bus.c   = c_r;
  assign bus.dz  = dz_r;
  assign bus.ovf = ovf_r;
  assign bus.unf = unf_r;
endmodule

// File: tb/tb_dlfloat_div_seq.sv
// Directed-vector bench for the iterative DLFloat16 divider.
module tb_dlfloat_div_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlfloat_div_seq_if bus();

  dlfloat_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] rc;
  logic        rdz, rovf, runf;
  int          rlat;

  // Drives one divide and captures result, flags and accept-to-valid latency.
  task automatic run_div(input logic [15:0] aa, input logic [15:0] bb);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.a = aa;
    bus.b = bb;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rlat = 1;
    while (!bus.out_valid && rlat < 40) begin
      @(posedge clk); #1;
      rlat++;
    end
    rc   = bus.c;
    rdz  = bus.dz;
    rovf = bus.ovf;
    runf = bus.unf;
    if (bus.out_ready && bus.out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = 16'h0;
    bus.b = 16'h0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.out_valid, bus.c, bus.dz, bus.ovf, bus.unf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b c=%h flags=%b%b%b want 0", bus.out_valid, bus.c, bus.dz, bus.ovf, bus.unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_normal;
    logic [15:0] va[3] = '{16'h4300, 16'h3E00, 16'hBE00};
    logic [15:0] vb[3] = '{16'h4000, 16'h4100, 16'h4000};
    logic [15:0] vc[3] = '{16'h4100, 16'h3AAB, 16'hBC00};
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i]);
      checks++;
      if (rc !== vc[i]) begin
        errors++;
        $display("FAIL normal_c[%0d] got %h want %h", i, rc, vc[i]);
      end
      checks++;
      if (rlat !== 14) begin
        errors++;
        $display("FAIL normal_latency[%0d] got %0d want 14", i, rlat);
      end
      checks++;
      if ({rdz, rovf, runf} !== 3'b000) begin
        errors++;
        $display("FAIL normal_flags[%0d] got %b want 000", i, {rdz, rovf, runf});
      end
    end
  endtask

  task automatic test_special;
    logic [15:0] va[5] = '{16'h4000, 16'h0000, 16'hFFFF, 16'h0000, 16'h01AC};
    logic [15:0] vb[5] = '{16'h0000, 16'h4300, 16'h3EA3, 16'h0000, 16'h4073};
    logic [15:0] vc[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic        vdz[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_div(va[i], vb[i]);
      checks++;
      if ({rc, rdz, rovf, runf} !== {vc[i], vdz[i], 2'b00}) begin
        errors++;
        $display("FAIL special[%0d] got c=%h flags=%b%b%b want c=%h flags=%b00", i, rc, rdz, rovf, runf, vc[i], vdz[i]);
      end
      checks++;
      if (rlat !== 1) begin
        errors++;
        $display("FAIL special_latency[%0d] got %0d want 1", i, rlat);
      end
    end
  endtask

  task automatic test_range;
    run_div(16'h7DFE, 16'h3C00);
    checks++;
    if ({rc, rdz, rovf, runf} !== {16'hFFFF, 3'b010}) begin
      errors++;
      $display("FAIL overflow got c=%h flags=%b%b%b want c=ffff flags=010", rc, rdz, rovf, runf);
    end
    run_div(16'h0200, 16'h4000);
    checks++;
    if ({rc, rdz, rovf, runf} !== {16'h0000, 3'b001}) begin
      errors++;
      $display("FAIL underflow got c=%h flags=%b%b%b want c=0000 flags=001", rc, rdz, rovf, runf);
    end
  endtask

  task automatic test_handshake;
    int n;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.a = 16'h4300;
    bus.b = 16'h4000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'hFFFF;
    bus.b = 16'h0000;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.c, bus.dz} !== {16'h4100, 1'b0} || n !== 14) begin
      errors++;
      $display("FAIL busy_ignore got c=%h dz=%b lat=%0d want c=4100 dz=0 lat=14", bus.c, bus.dz, n);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.c} !== {2'b10, 16'h4100}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got ov=%b ir=%b c=%h want ov=1 ir=0 c=4100", i, bus.out_valid, bus.in_ready, bus.c);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
    run_div(16'h3E00, 16'h4100);
    checks++;
    if (rc !== 16'h3AAB || rlat !== 14) begin
      errors++;
      $display("FAIL next_after_release got c=%h lat=%0d want c=3aab lat=14", rc, rlat);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.a = 16'h4300;
    bus.b = 16'h4000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.c, bus.in_ready} !== {1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got ov=%b c=%h ir=%b want ov=0 c=0000 ir=1", bus.out_valid, bus.c, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_div(16'h4300, 16'h4000);
    checks++;
    if (rc !== 16'h4100 || rlat !== 14) begin
      errors++;
      $display("FAIL after_reset got c=%h lat=%0d want c=4100 lat=14", rc, rlat);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_special;
    test_range;
    test_handshake;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
